// File: rtl/player_state_tx_if.sv
// Dibit stream link from the player-state framer toward the PHY/MAC path.
interface player_state_tx_if;
    logic       axiov;
    logic [1:0] axiod;
    logic       axiready;

    modport master (output axiov, output axiod, input axiready);
    modport slave  (input axiov, input axiod, output axiready);
endinterface

// File: rtl/player_state_tx.sv
// Frames a per-frame snapshot of local player state into a 7-byte packet
// (sync, 5 payload bytes, XOR checksum) and streams it as LSB-first dibits.
//
// state | meaning
// IDLE  | waiting for send_strobe, stream quiet
// SEND  | presenting dibits 0..27 of the frozen packet
// GAP   | inter-frame gap, IFG_CYCLES cycles with axiov low
module player_state_tx #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned IFG_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    send_strobe,
    input  logic [10:0]             player_x,
    input  logic [10:0]             player_y,
    input  logic [8:0]              player_direction,
    input  logic [2:0]              game_stat,
    input  logic                    rst_flag,
    player_state_tx_if.master       axis,
    output logic                    busy,
    output logic [15:0]             tx_count,
    output logic [7:0]              drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LOAD  = 8'(IFG_CYCLES - 1);
    localparam logic [4:0] LAST_DIBIT = 5'd27;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [39:0] r_word;
    logic [7:0]  r_chk;
    logic [4:0]  r_idx;
    logic [7:0]  r_gap;
    logic [15:0] r_tx_count;
    logic [7:0]  r_drop_count;

    logic        w_axiov;
    logic        w_busy;
    logic        w_accept;
    logic        w_xfer;
    logic        w_last;
    logic [39:0] w_word_in;
    logic [7:0]  w_chk_in;
    logic [7:0]  w_byte;
    logic [1:0]  w_dibit;

    assign w_word_in = {5'b0, rst_flag, game_stat, player_direction, player_y, player_x};
    assign w_chk_in  = w_word_in[7:0] ^ w_word_in[15:8] ^ w_word_in[23:16]
                     ^ w_word_in[31:24] ^ w_word_in[39:32];

    assign w_accept = (r_state == ST_IDLE) && send_strobe;
    assign w_xfer   = (r_state == ST_SEND) && axis.axiready;
    assign w_last   = w_xfer && (r_idx == LAST_DIBIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_axiov     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (send_strobe) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                w_axiov = 1'b1;
                w_busy  = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_busy = 1'b1;
                if (r_gap == 8'd0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word       <= '0;
            r_chk        <= '0;
            r_idx        <= '0;
            r_gap        <= '0;
            r_tx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_accept) begin
                r_word <= w_word_in;
                r_chk  <= w_chk_in;
                r_idx  <= '0;
            end else if (w_xfer) begin
                r_idx <= r_idx + 5'd1;
            end

            if (w_last) begin
                r_tx_count <= r_tx_count + 16'd1;
                r_gap      <= GAP_LOAD;
            end else if ((r_state == ST_GAP) && (r_gap != 8'd0)) begin
                r_gap <= r_gap - 8'd1;
            end

            // Any strobe outside IDLE is lost, including the one on the final transfer.
            if (send_strobe && (r_state != ST_IDLE) && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_byte = SYNC_BYTE;
        case (r_idx[4:2])
            3'd0:    w_byte = SYNC_BYTE;
            3'd1:    w_byte = r_word[7:0];
            3'd2:    w_byte = r_word[15:8];
            3'd3:    w_byte = r_word[23:16];
            3'd4:    w_byte = r_word[31:24];
            3'd5:    w_byte = r_word[39:32];
            3'd6:    w_byte = r_chk;
            default: w_byte = SYNC_BYTE;
        endcase
    end

    always_comb begin
        w_dibit = 2'b00;
        case (r_idx[1:0])
            2'd0:    w_dibit = w_byte[1:0];
            2'd1:    w_dibit = w_byte[3:2];
            2'd2:    w_dibit = w_byte[5:4];
            default: w_dibit = w_byte[7:6];
        endcase
    end

    assign axis.axiov = w_axiov;
    assign axis.axiod = w_axiov ? w_dibit : 2'b00;
    assign busy       = w_busy;
    assign tx_count   = r_tx_count;
    assign drop_count = r_drop_count;

endmodule

// File: doc/player_state_tx.md
Name: player_state_tx

Overview:
- Transmit side of the kart-to-kart link. Once per frame, snapshots the local player state: position, direction, game status and reset flag.
- Frames the snapshot into a 7-byte packet with sync byte and XOR checksum.
- Streams the packet as LSB-first dibits on an AXI-stream-style valid/ready interface toward the network PHY/MAC path.
- The peer's receiver recovers these fields as its opponent x/y/direction/game/reset inputs.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every packet.
- IFG_CYCLES, 4, idle cycles with axiov low after each packet before the next strobe is accepted (range 1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- send_strobe  input  1  one-cycle frame tick requesting a packet
- player_x  input  11  local x position
- player_y  input  11  local y position
- player_direction  input  9  heading, 0..359
- game_stat  input  3  local game status
- rst_flag  input  1  local game-reset indication carried to peer
- axiready  input  1  downstream ready
- axiov  output  1  dibit valid
- axiod  output  2  dibit data
- busy  output  1  high in SEND or GAP
- tx_count  output  16  completed packets, wraps at 65535->0
- drop_count  output  8  rejected strobes, saturates at 255

Behaviour:
- Reset (async, any state): state=IDLE; axiov=0, axiod=0, busy=0, tx_count=0, drop_count=0; the snapshot register and checksum clear. A packet in flight is abandoned immediately, with no further dibits.
- Packing on strobe acceptance: 40-bit word W.
  - W[10:0]=player_x, W[21:11]=player_y, W[30:22]=player_direction, W[33:31]=game_stat, W[34]=rst_flag, W[39:35]=0.
  - Payload byte bk=W[8k+7:8k], k=0..4; chk = b0^b1^b2^b3^b4.
- Packet order: SYNC_BYTE, b0, b1, b2, b3, b4, chk. 7 bytes = 28 dibits. Within a byte, dibit order is [1:0], [3:2], [5:4], [7:6].
- States:
  - IDLE: axiov=0, busy=0. send_strobe=1 captures all inputs on that edge and moves to SEND. axiov=1 with the first SYNC dibit in the next cycle (latency 1).
  - SEND: axiov=1. A dibit transfers when axiov&&axiready. axiod is held stable while axiready=0, and the stall length is unbounded. A 5-bit dibit index increments per transfer. On the transfer of dibit 27: tx_count+1, go to GAP, and axiov=0 next cycle.
  - GAP: axiov=0, busy=1. Counts IFG_CYCLES cycles, then goes to IDLE.
- Snapshot is frozen for the whole packet; input changes during SEND do not affect the bytes sent.
- send_strobe while in SEND or GAP, including the cycle of the last transfer: ignored, and drop_count+1 (saturating). A strobe in IDLE always succeeds.
- axiod=0 whenever axiov=0.
- axiready is ignored outside SEND.

Test Plan:
- Basic packet: reset; x=100, y=100, dir=90, game=0, rst_flag=0; strobe; axiready=1 -> bytes A5,64,20,83,16,00,D1. First dibits 1,1,2,2. axiov high exactly 28 cycles starting the cycle after strobe. tx_count=1.
- Extreme fields: x=992, y=736, dir=359, game=1, rst_flag=1 -> bytes A5,E0,03,D7,D9,04,E9.
- Backpressure: basic packet with axiready toggled 1,0,0,1 repeating -> axiod holds during stalls, same 7 bytes decoded, tx_count=1. Changing x mid-packet does not alter the output.
- Overrun: strobe during SEND and during GAP -> no second packet, drop_count=2. Strobe on the first IDLE cycle after IFG_CYCLES=4 gap cycles -> new packet starts next cycle. 300 busy strobes -> drop_count=255.
- Async reset mid-packet: assert rst after 10 dibits, without a clock edge -> axiov=0 immediately, all counters 0. After release, a strobe sends a complete fresh packet starting with SYNC.
- Bench check: a loopback decoder reassembles W and checks the XOR checksum over 1000 random snapshots with random axiready -> all fields match and the checksum verifies.
